// File: rtl/axi4_mem_slave.sv
// AXI4 memory responder: independent read/write burst engines over one dual-port RAM.
// Supports FIXED/INCR/WRAP bursts; illegal bursts run as INCR and answer SLVERR.
module axi4_mem_slave #(
    parameter int AW         = 32,
    parameter int DW         = 64,
    parameter int IDW        = 4,
    parameter int DEPTH_LOG2 = 10,
    localparam int ADDR_LSB  = $clog2(DW/8)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_axi_arvalid,
    input  logic [AW-1:0]     s_axi_araddr,
    input  logic [IDW-1:0]    s_axi_arid,
    input  logic [1:0]        s_axi_arburst,
    input  logic [7:0]        s_axi_arlen,
    output logic              s_axi_arready,
    output logic              s_axi_rvalid,
    output logic [DW-1:0]     s_axi_rdata,
    output logic [IDW-1:0]    s_axi_rid,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    input  logic              s_axi_rready,
    input  logic              s_axi_awvalid,
    input  logic [AW-1:0]     s_axi_awaddr,
    input  logic [IDW-1:0]    s_axi_awid,
    input  logic [1:0]        s_axi_awburst,
    input  logic [7:0]        s_axi_awlen,
    output logic              s_axi_awready,
    input  logic              s_axi_wvalid,
    input  logic [DW-1:0]     s_axi_wdata,
    input  logic [DW/8-1:0]   s_axi_wstrb,
    input  logic              s_axi_wlast,
    output logic              s_axi_wready,
    output logic              s_axi_bvalid,
    output logic [IDW-1:0]    s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_bready
);
    localparam int NB = DW/8;
    typedef logic [DEPTH_LOG2-1:0] word_t;
    typedef enum logic       {R_IDLE, R_BURST} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [DW-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    function automatic logic bad_burst(input logic [1:0] b, input logic [7:0] len);
        return (b == 2'd3) || ((b == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    // WRAP keeps the upper word bits and lets the low log2(len+1) bits roll over.
    function automatic word_t next_word(input word_t w, input logic [7:0] len, input logic [1:0] b);
        word_t m;
        m = word_t'(len);
        case (b)
            2'd0:    return w;
            2'd2:    return (w & ~m) | ((w + 1'b1) & m);
            default: return w + 1'b1;
        endcase
    endfunction

    // ---------------- read path ----------------
    rstate_t        rs_q;
    word_t          rword_q, rword_d, ar_word;
    logic [7:0]     rlen_q, rbeat_q;
    logic [1:0]     rburst_q;
    logic           rvalid_q, rlast_q;
    logic [DW-1:0]  rdata_q;
    logic [IDW-1:0] rid_q;
    logic [1:0]     rresp_q;
    logic           ar_bad;

    assign ar_word = s_axi_araddr[ADDR_LSB +: DEPTH_LOG2];
    assign ar_bad  = bad_burst(s_axi_arburst, s_axi_arlen);
    assign rword_d = next_word(rword_q, rlen_q, rburst_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs_q     <= R_IDLE;
            rword_q  <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            rburst_q <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            rresp_q  <= '0;
        end else begin
            case (rs_q)
                R_IDLE: if (s_axi_arvalid) begin
                    rs_q     <= R_BURST;
                    rword_q  <= ar_word;
                    rlen_q   <= s_axi_arlen;
                    rburst_q <= ar_bad ? 2'd1 : s_axi_arburst;
                    rbeat_q  <= '0;
                    rvalid_q <= 1'b1;
                    rlast_q  <= (s_axi_arlen == 8'd0);
                    rdata_q  <= mem[ar_word];
                    rid_q    <= s_axi_arid;
                    rresp_q  <= ar_bad ? 2'd2 : 2'd0;
                end
                R_BURST: if (s_axi_rready) begin
                    if (rlast_q) begin
                        rs_q     <= R_IDLE;
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                    end else begin
                        // prefetch the next beat so handshakes can run every cycle
                        rword_q  <= rword_d;
                        rbeat_q  <= rbeat_q + 8'd1;
                        rlast_q  <= (8'(rbeat_q + 8'd1) == rlen_q);
                        rdata_q  <= mem[rword_d];
                    end
                end
                default: rs_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_arready = (rs_q == R_IDLE);
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;

    // ---------------- write path ----------------
    wstate_t        ws_q;
    word_t          wword_q;
    logic [7:0]     wlen_q, wbeat_q;
    logic [1:0]     wburst_q;
    logic           werr_q;
    logic [IDW-1:0] bid_q;
    logic [1:0]     bresp_q;
    logic           aw_bad, w_fire;

    assign aw_bad = bad_burst(s_axi_awburst, s_axi_awlen);
    assign w_fire = (ws_q == W_DATA) && s_axi_wvalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ws_q     <= W_IDLE;
            wword_q  <= '0;
            wlen_q   <= '0;
            wbeat_q  <= '0;
            wburst_q <= '0;
            werr_q   <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
        end else begin
            case (ws_q)
                W_IDLE: if (s_axi_awvalid) begin
                    ws_q     <= W_DATA;
                    wword_q  <= s_axi_awaddr[ADDR_LSB +: DEPTH_LOG2];
                    wlen_q   <= s_axi_awlen;
                    wbeat_q  <= '0;
                    wburst_q <= aw_bad ? 2'd1 : s_axi_awburst;
                    werr_q   <= aw_bad;
                    bid_q    <= s_axi_awid;
                end
                W_DATA: if (s_axi_wvalid) begin
                    wword_q <= next_word(wword_q, wlen_q, wburst_q);
                    wbeat_q <= wbeat_q + 8'd1;
                    if (wbeat_q == wlen_q) begin
                        ws_q    <= W_RESP;
                        bresp_q <= (werr_q || !s_axi_wlast) ? 2'd2 : 2'd0;
                    end else if (s_axi_wlast) begin
                        werr_q  <= 1'b1;
                    end
                end
                W_RESP: if (s_axi_bready) ws_q <= W_IDLE;
                default: ws_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi_wstrb[b]) mem[wword_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi_awready = (ws_q == W_IDLE);
    assign s_axi_wready  = (ws_q == W_DATA);
    assign s_axi_bvalid  = (ws_q == W_RESP);
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;

    // Address bits outside the word index are intentionally ignored (memory aliases).
    logic unused_addr;
    assign unused_addr = ^{s_axi_araddr, s_axi_awaddr};
endmodule
